ddr3_axi_responder: RTL

Synthesizable stand-in for the DDR3 controller's user AXI port: it answers the same awaddr/wready/araddr/rvalid handshakes the DDR3 controller presents, backed by on-chip block RAM instead of external memory. It sits where the DDR3 controller instance normally sits, so traffic generators and checkers run in simulation and on-board without the DDR PHY. It also drives a delayed ddr_init_done so initiator start-up logic is exercised unchanged.

---
 rtl/ddr3_axi_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_axi_responder.sv
// BRAM-backed stand-in for the DDR3 controller user AXI port.
// Serializes write and read bursts and emits a delayed init-done.
module ddr3_axi_responder #(
    parameter int MEM_AW      = 8,
    parameter int INIT_CYCLES = 64,
    parameter int RD_LAT      = 2
) (
    input  logic         core_clk,
    input  logic         i_rst_n,
    output logic         ddr_init_done,
    input  logic [27:0]  axi_awaddr,
    input  logic [3:0]   axi_awuser_id,
    input  logic [3:0]   axi_awlen,
    input  logic         axi_awvalid,
    output logic         axi_awready,
    input  logic [255:0] axi_wdata,
    input  logic [31:0]  axi_wstrb,
    output logic         axi_wready,
    output logic [3:0]   axi_wusero_id,
    output logic         axi_wusero_last,
    input  logic [27:0]  axi_araddr,
    input  logic [3:0]   axi_aruser_id,
    input  logic [3:0]   axi_arlen,
    input  logic         axi_arvalid,
    output logic         axi_arready,
    output logic [255:0] axi_rdata,
    output logic [3:0]   axi_rid,
    output logic         axi_rvalid,
    output logic         axi_rlast
);

    localparam int ICW = $clog2(INIT_CYCLES + 2);
    localparam logic [ICW-1:0]    INIT_END = ICW'(INIT_CYCLES);
    localparam logic [ICW-1:0]    INIT_ONE = 1;
    localparam logic [MEM_AW-1:0] PTR_ONE  = 1;
    localparam logic [3:0]        WAIT_LD  = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_RD
    } state_t;

    state_t              r_state;
    logic [ICW-1:0]      r_init;
    logic                r_last_wr;
    logic [MEM_AW-1:0]   r_ptr;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [3:0]          r_wait;
    logic                r_wready;
    logic                r_wlast;
    logic [3:0]          r_wid;
    logic                r_rvalid;
    logic                r_rlast;
    logic [3:0]          r_rid;
    logic [255:0]        r_rdata;
    logic [255:0]        r_mem [2**MEM_AW];

    logic w_grant_wr;
    logic w_grant_rd;
    logic w_idle_rdy;
    logic w_unused;

    // Address bits outside the word index are deliberately aliased.
    assign w_unused = &{1'b0, axi_awaddr, axi_araddr};

    // Init counter: counts cycles after reset release, saturates.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init <= '0;
        end else if (r_init != INIT_END) begin
            r_init <= r_init + INIT_ONE;
        end
    end

    assign ddr_init_done = (r_init == INIT_END);

    // On a tie the side not served last wins; reset treats read as last.
    assign w_grant_wr  = axi_awvalid & (~axi_arvalid | ~r_last_wr);
    assign w_grant_rd  = axi_arvalid & (~axi_awvalid | r_last_wr);
    assign w_idle_rdy  = (r_state == S_IDLE) & ddr_init_done;
    assign axi_awready = w_idle_rdy & w_grant_wr;
    assign axi_arready = w_idle_rdy & w_grant_rd;

    // Burst FSM with registered handshake and read-data outputs.
    always_ff @(posedge core_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b0;
            r_ptr     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_wready  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wid     <= '0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (axi_awready) begin
                        r_state   <= S_WR;
                        r_last_wr <= 1'b1;
                        r_ptr     <= axi_awaddr[MEM_AW+2:3];
                        r_len     <= axi_awlen;
                        r_cnt     <= '0;
                        r_wid     <= axi_awuser_id;
                        r_wready  <= 1'b1;
                        r_wlast   <= (axi_awlen == 4'd0);
                    end else if (axi_arready) begin
                        r_state   <= S_RD_WAIT;
                        r_last_wr <= 1'b0;
                        r_ptr     <= axi_araddr[MEM_AW+2:3];
                        r_len     <= axi_arlen;
                        r_cnt     <= '0;
                        r_rid     <= axi_aruser_id;
                        r_wait    <= WAIT_LD;
                    end
                end
                S_WR: begin
                    r_ptr <= r_ptr + PTR_ONE;
                    if (r_cnt == r_len) begin
                        r_state  <= S_IDLE;
                        r_wready <= 1'b0;
                        r_wlast  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_wlast <= (r_cnt + 4'd1 == r_len);
                    end
                end
                S_RD_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_state  <= S_RD;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_len == 4'd0);
                        r_rdata  <= r_mem[r_ptr];
                        r_ptr    <= r_ptr + PTR_ONE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_RD: begin
                    if (r_cnt == r_len) begin
                        r_state  <= S_IDLE;
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_rlast <= (r_cnt + 4'd1 == r_len);
                        r_rdata <= r_mem[r_ptr];
                        r_ptr   <= r_ptr + PTR_ONE;
                    end
                end
            endcase
        end
    end

    // Byte-masked RAM write; contents survive reset.
    always_ff @(posedge core_clk) begin
        if (r_wready) begin
            for (int i = 0; i < 32; i++) begin
                if (axi_wstrb[i]) begin
                    r_mem[r_ptr][8*i +: 8] <= axi_wdata[8*i +: 8];
                end
            end
        end
    end

    assign axi_wready      = r_wready;
    assign axi_wusero_last = r_wlast;
    assign axi_wusero_id   = r_wid;
    assign axi_rvalid      = r_rvalid;
    assign axi_rlast       = r_rlast;
    assign axi_rid         = r_rid;
    assign axi_rdata       = r_rdata;

endmodule
